// File: rtl/rou_pkg.sv
// Shared ROU message definitions: kind encodings, field offsets and width helpers.
package rou_pkg;

    typedef enum logic [1:0] {
        ROU_IDLE  = 2'b00,
        ROU_WRITE = 2'b01,
        ROU_RDREQ = 2'b10,
        ROU_RDRSP = 2'b11
    } rou_kind_e;

    localparam int KIND_W   = 2;
    localparam int OFF_KIND = 0;
    localparam int OFF_TAG  = KIND_W;

    function automatic int off_bsel(input int twid);
        return OFF_TAG + twid;
    endfunction

    function automatic int off_addr(input int twid, input int bwid);
        return off_bsel(twid) + bwid;
    endfunction

    function automatic int off_data(input int twid, input int bwid, input int awid);
        return off_addr(twid, bwid) + awid;
    endfunction

    function automatic int bwid_sel(input int dwid);
        case (dwid)
            512:     return 6;
            256:     return 5;
            128:     return 4;
            64:      return 3;
            default: return 2;
        endcase
    endfunction

endpackage

// File: rtl/rou_tag_alloc.sv
// Outstanding-read tag tracker: tags 1..NOUT, lowest free tag offered for allocation.
module rou_tag_alloc #(
    parameter int NOUT = 4,
    parameter int TWID = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alloc,
    input  logic            free,
    input  logic [TWID-1:0] free_tag,
    output logic [TWID-1:0] alloc_tag,
    output logic [NOUT-1:0] pending,
    output logic            any_free,
    output logic            any_busy
);

    logic [NOUT-1:0] pend_p1;
    logic [NOUT-1:0] pend_next;

    // Offer is taken from the registered vector only, so a freed tag is reusable a cycle later.
    always_comb begin
        alloc_tag = '0;
        for (int i = NOUT - 1; i >= 0; i--) begin
            if (!pend_p1[i]) alloc_tag = TWID'(i + 1);
        end
    end

    always_comb begin
        pend_next = pend_p1;
        for (int i = 0; i < NOUT; i++) begin
            if (free && free_tag == TWID'(i + 1)) pend_next[i] = 1'b0;
            if (alloc && alloc_tag == TWID'(i + 1)) pend_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_p1 <= '0;
        else        pend_p1 <= pend_next;
    end

    assign pending  = pend_p1;
    assign any_free = ~&pend_p1;
    assign any_busy = |pend_p1;

endmodule

// File: rtl/rou_initiator.sv
// ROU bus initiator: local requests to ROU request messages, read responses back to a local port.
module rou_initiator
    import rou_pkg::*;
#(
    parameter int DWID = 128,
    parameter int AWID = 32,
    parameter int TWID = 5,
    parameter int NOUT = 4,
    localparam int BWID = bwid_sel(DWID),
    localparam int WID  = 2 + DWID + AWID + BWID + TWID
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [AWID-1:0] req_addr,
    input  logic [DWID-1:0] req_wdata,
    input  logic [BWID-1:0] req_bsel,
    output logic [WID-1:0]  rou_out,
    output logic            rou_out_seen,
    input  logic [2:0]      ack_out,
    input  logic [WID-1:0]  rou_in,
    input  logic            rou_in_seen,
    output logic [2:0]      ack_in,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [TWID-1:0] rsp_tag,
    output logic [DWID-1:0] rsp_data,
    output logic            busy,
    output logic            err_unexp
);

    localparam int OFF_BSEL = off_bsel(TWID);
    localparam int OFF_ADDR = off_addr(TWID, BWID);
    localparam int OFF_DATA = off_data(TWID, BWID, AWID);

    logic [WID-1:0]  out_msg_p1;
    logic [WID-1:0]  req_msg;
    logic            out_full;
    logic            take;
    logic            alloc;
    logic [TWID-1:0] alloc_tag;
    logic [NOUT-1:0] pending;
    logic            any_free;
    logic            any_busy;
    rou_kind_e       in_kind;
    logic [TWID-1:0] in_tag;
    logic            tag_ok;
    logic            rsp_take;
    logic            drop;
    logic            rsp_vld_p1;
    logic [TWID-1:0] rsp_tag_p1;
    logic [DWID-1:0] rsp_data_p1;
    logic            unused_in;

    // Request side: the holding register may reload in the same edge it is acknowledged.
    assign out_full  = |out_msg_p1[OFF_KIND +: KIND_W];
    assign req_ready = (!out_full || (|ack_out)) && (req_write || any_free);
    assign take      = req_valid && req_ready;
    assign alloc     = take && !req_write;

    always_comb begin
        req_msg                      = '0;
        req_msg[OFF_BSEL +: BWID]    = req_bsel;
        req_msg[OFF_ADDR +: AWID]    = req_addr;
        if (req_write) begin
            req_msg[OFF_KIND +: KIND_W] = ROU_WRITE;
            req_msg[OFF_DATA +: DWID]   = req_wdata;
        end else begin
            req_msg[OFF_KIND +: KIND_W] = ROU_RDREQ;
            req_msg[OFF_TAG +: TWID]    = alloc_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            out_msg_p1 <= '0;
        else if (take)         out_msg_p1 <= req_msg;
        else if (|ack_out)     out_msg_p1 <= '0;
    end

    rou_tag_alloc #(
        .NOUT (NOUT),
        .TWID (TWID)
    ) u_tags (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc     (alloc),
        .free      (rsp_take),
        .free_tag  (in_tag),
        .alloc_tag (alloc_tag),
        .pending   (pending),
        .any_free  (any_free),
        .any_busy  (any_busy)
    );

    // Response side: accept only tags we issued; everything else non-idle is swallowed and flagged.
    assign in_kind = rou_kind_e'(rou_in[OFF_KIND +: KIND_W]);
    assign in_tag  = rou_in[OFF_TAG +: TWID];

    always_comb begin
        tag_ok = 1'b0;
        for (int i = 0; i < NOUT; i++) begin
            if (in_tag == TWID'(i + 1) && pending[i]) tag_ok = 1'b1;
        end
    end

    assign rsp_take = rst_n && (in_kind == ROU_RDRSP) && tag_ok && (!rsp_vld_p1 || rsp_ready);
    assign drop     = rst_n && (in_kind != ROU_IDLE) && !((in_kind == ROU_RDRSP) && tag_ok);
    assign ack_in   = {2'b00, rsp_take || drop};
    assign err_unexp = drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_p1  <= 1'b0;
            rsp_tag_p1  <= '0;
            rsp_data_p1 <= '0;
        end else if (rsp_take) begin
            rsp_vld_p1  <= 1'b1;
            rsp_tag_p1  <= in_tag;
            rsp_data_p1 <= rou_in[OFF_DATA +: DWID];
        end else if (rsp_ready) begin
            rsp_vld_p1  <= 1'b0;
        end
    end

    assign rou_out      = out_msg_p1;
    assign rou_out_seen = 1'b0;
    assign rsp_valid    = rsp_vld_p1;
    assign rsp_tag      = rsp_tag_p1;
    assign rsp_data     = rsp_data_p1;
    assign busy         = out_full || any_busy;
    assign unused_in    = ^{rou_in_seen, rou_in[OFF_DATA-1:OFF_BSEL]};

endmodule

// File: tb/tb_rou_initiator.sv
// Directed and randomized bench for rou_initiator with a behavioural reference model.
module tb_rou_initiator;

    localparam int DWID = 128;
    localparam int AWID = 32;
    localparam int TWID = 5;
    localparam int NOUT = 4;
    localparam int BWID = 4;
    localparam int WID  = 2 + DWID + AWID + BWID + TWID;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [AWID-1:0] req_addr;
    logic [DWID-1:0] req_wdata;
    logic [BWID-1:0] req_bsel;
    logic [WID-1:0]  rou_out;
    logic            rou_out_seen;
    logic [2:0]      ack_out;
    logic [WID-1:0]  rou_in;
    logic            rou_in_seen;
    logic [2:0]      ack_in;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [TWID-1:0] rsp_tag;
    logic [DWID-1:0] rsp_data;
    logic            busy;
    logic            err_unexp;

    int checks = 0;
    int errors = 0;

    rou_initiator #(
        .DWID (DWID),
        .AWID (AWID),
        .TWID (TWID),
        .NOUT (NOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_bsel     (req_bsel),
        .rou_out      (rou_out),
        .rou_out_seen (rou_out_seen),
        .ack_out      (ack_out),
        .rou_in       (rou_in),
        .rou_in_seen  (rou_in_seen),
        .ack_in       (ack_in),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_tag      (rsp_tag),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .err_unexp    (err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WID-1:0] mk(input logic [1:0] kind, input logic [TWID-1:0] tag,
                                          input logic [BWID-1:0] bsel, input logic [AWID-1:0] addr,
                                          input logic [DWID-1:0] data);
        return {data, addr, bsel, tag, kind};
    endfunction

    function automatic logic [DWID-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_bsel = '0;
        ack_out = 3'd0; rou_in = '0; rou_in_seen = 0; rsp_ready = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        checks++; if (rou_out !== '0) begin errors++; $display("FAIL reset_rou_out: got %0h expected 0", rou_out); end
        checks++; if (rou_out_seen !== 1'b0) begin errors++; $display("FAIL reset_seen: got %b expected 0", rou_out_seen); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (ack_in !== 3'd0) begin errors++; $display("FAIL reset_ack_in: got %0d expected 0", ack_in); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_tag !== '0) begin errors++; $display("FAIL reset_rsp_tag: got %0d expected 0", rsp_tag); end
        checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %0h expected 0", rsp_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_unexp); end
        rst_n = 1'b1;
        next_cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_write_hold();
        logic [DWID-1:0] wd;
        logic [WID-1:0]  exp;
        wd  = {16{8'hA5}};
        exp = mk(2'b01, '0, 4'd3, 32'h10, wd);
        req_valid = 1; req_write = 1; req_addr = 32'h10; req_wdata = wd; req_bsel = 4'd3; ack_out = 3'd0;
        #2;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL write_accept_ready: got %b expected 1", req_ready); end
        next_cycle();
        req_valid = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) ack_out = 3'd1;
            #2;
            checks++; if (rou_out !== exp) begin errors++; $display("FAIL write_hold_out c%0d: got %0h expected %0h", c, rou_out, exp); end
            checks++; if (req_ready !== (c == 3)) begin errors++; $display("FAIL write_hold_ready c%0d: got %b expected %b", c, req_ready, (c == 3)); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_hold_busy c%0d: got %b expected 1", c, busy); end
            next_cycle();
        end
        ack_out = 3'd0;
        req_write = 0;
        #2;
        checks++; if (rou_out !== '0) begin errors++; $display("FAIL write_cleared: got %0h expected 0", rou_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_cleared_busy: got %b expected 0", busy); end
        next_cycle();
    endtask

    task automatic test_reads_full();
        logic [AWID-1:0] a;
        logic [BWID-1:0] b;
        logic [DWID-1:0] wd;
        ack_out = 3'd1; req_write = 0; req_valid = 1;
        for (int k = 1; k <= NOUT; k++) begin
            a = $urandom(); b = BWID'($urandom_range(0, 15));
            req_addr = a; req_bsel = b; req_wdata = rand_data();
            #2;
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL read%0d_ready: got %b expected 1", k, req_ready); end
            next_cycle();
            checks++; if (rou_out !== mk(2'b10, TWID'(k), b, a, '0)) begin errors++; $display("FAIL read%0d_msg: got %0h expected %0h", k, rou_out, mk(2'b10, TWID'(k), b, a, '0)); end
        end
        req_addr = 32'h500;
        #2;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL read5_ready: got %b expected 0", req_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read5_busy: got %b expected 1", busy); end
        next_cycle();
        wd = rand_data();
        req_write = 1; req_addr = 32'h200; req_wdata = wd; req_bsel = 4'd1;
        #2;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_write_ready: got %b expected 1", req_ready); end
        next_cycle();
        req_valid = 0; req_write = 0;
        checks++; if (rou_out !== mk(2'b01, '0, 4'd1, 32'h200, wd)) begin errors++; $display("FAIL full_write_msg: got %0h expected %0h", rou_out, mk(2'b01, '0, 4'd1, 32'h200, wd)); end
        next_cycle();
        ack_out = 3'd0;
        checks++; if (rou_out !== '0) begin errors++; $display("FAIL full_out_cleared: got %0h expected 0", rou_out); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_tags: got %b expected 1", busy); end
    endtask

    task automatic test_response();
        rsp_ready = 1;
        rou_in = mk(2'b11, 5'd2, '0, '0, 128'h1234);
        req_valid = 1; req_write = 0; req_addr = 32'h300; req_bsel = 4'd5;
        #2;
        checks++; if (ack_in !== 3'd1) begin errors++; $display("FAIL rsp_ack: got %0d expected 1", ack_in); end
        checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL rsp_err: got %b expected 0", err_unexp); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rsp_same_cycle_ready: got %b expected 0", req_ready); end
        next_cycle();
        rou_in = '0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_tag !== 5'd2) begin errors++; $display("FAIL rsp_tag: got %0d expected 2", rsp_tag); end
        checks++; if (rsp_data !== 128'h1234) begin errors++; $display("FAIL rsp_data: got %0h expected 1234", rsp_data); end
        #2;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL realloc_ready: got %b expected 1", req_ready); end
        next_cycle();
        req_valid = 0;
        checks++; if (rou_out !== mk(2'b10, 5'd2, 4'd5, 32'h300, '0)) begin errors++; $display("FAIL realloc_msg: got %0h expected %0h", rou_out, mk(2'b10, 5'd2, 4'd5, 32'h300, '0)); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_drained: got %b expected 0", rsp_valid); end
        ack_out = 3'd1;
        next_cycle();
        ack_out = 3'd0;
    endtask

    task automatic test_backpressure();
        logic [DWID-1:0] da;
        logic [DWID-1:0] db;
        da = rand_data(); db = rand_data();
        rsp_ready = 0;
        rou_in = mk(2'b11, 5'd1, '0, '0, da);
        #2;
        checks++; if (ack_in !== 3'd1) begin errors++; $display("FAIL bp_first_ack: got %0d expected 1", ack_in); end
        next_cycle();
        rou_in = mk(2'b11, 5'd3, '0, '0, db);
        checks++; if (rsp_data !== da) begin errors++; $display("FAIL bp_first_data: got %0h expected %0h", rsp_data, da); end
        for (int c = 0; c < 2; c++) begin
            #2;
            checks++; if (ack_in !== 3'd0) begin errors++; $display("FAIL bp_refuse c%0d: got %0d expected 0", c, ack_in); end
            next_cycle();
            checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 5'd1) begin errors++; $display("FAIL bp_hold c%0d: got v=%b tag=%0d expected v=1 tag=1", c, rsp_valid, rsp_tag); end
        end
        rsp_ready = 1;
        #2;
        checks++; if (ack_in !== 3'd1) begin errors++; $display("FAIL bp_release_ack: got %0d expected 1", ack_in); end
        next_cycle();
        rou_in = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 5'd3) begin errors++; $display("FAIL bp_second: got v=%b tag=%0d expected v=1 tag=3", rsp_valid, rsp_tag); end
        checks++; if (rsp_data !== db) begin errors++; $display("FAIL bp_second_data: got %0h expected %0h", rsp_data, db); end
        next_cycle();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_unexpected();
        logic [WID-1:0] msgs [3];
        msgs[0] = mk(2'b11, 5'd7, '0, '0, rand_data());
        msgs[1] = mk(2'b11, 5'd1, '0, '0, rand_data());
        msgs[2] = mk(2'b01, 5'd0, 4'd2, 32'h44, rand_data());
        for (int m = 0; m < 3; m++) begin
            rou_in = msgs[m];
            #2;
            checks++; if (ack_in !== 3'd1) begin errors++; $display("FAIL unexp%0d_ack: got %0d expected 1", m, ack_in); end
            checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL unexp%0d_err: got %b expected 1", m, err_unexp); end
            next_cycle();
            rou_in = '0;
            #2;
            checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL unexp%0d_pulse: got %b expected 0", m, err_unexp); end
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL unexp%0d_rsp: got %b expected 0", m, rsp_valid); end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1; req_write = 0; req_addr = 32'h400; req_bsel = 4'd0; ack_out = 3'd0;
        next_cycle();
        req_valid = 0;
        checks++; if (rou_out !== mk(2'b10, 5'd1, 4'd0, 32'h400, '0)) begin errors++; $display("FAIL mid_out: got %0h expected %0h", rou_out, mk(2'b10, 5'd1, 4'd0, 32'h400, '0)); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (rou_out !== '0) begin errors++; $display("FAIL mid_rst_out: got %0h expected 0", rou_out); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", req_ready); end
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || ack_in !== 3'd0) begin errors++; $display("FAIL mid_rst_state: got busy=%b rv=%b ack=%0d expected 0 0 0", busy, rsp_valid, ack_in); end
        next_cycle();
        #2;
        rst_n = 1;
        next_cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_release_busy: got %b expected 0", busy); end
        rou_in = mk(2'b11, 5'd2, '0, '0, rand_data());
        #2;
        checks++; if (ack_in !== 3'd1 || err_unexp !== 1'b1) begin errors++; $display("FAIL mid_late_rsp: got ack=%0d err=%b expected 1 1", ack_in, err_unexp); end
        next_cycle();
        rou_in = '0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_late_rsp_valid: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_random();
        logic [WID-1:0]  m_out;
        logic            m_pend [1:NOUT];
        logic            m_rv;
        logic [TWID-1:0] m_rt;
        logic [DWID-1:0] m_rd;
        logic            exp_rdy, exp_err, exp_busy, known, acc, any_free;
        logic [2:0]      exp_ack;
        logic [1:0]      ik;
        logic [TWID-1:0] itag;
        int              lowest, r;
        m_out = '0; m_rv = 0; m_rt = '0; m_rd = '0;
        for (int t = 1; t <= NOUT; t++) m_pend[t] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_write = ($urandom_range(0, 2) == 0);
            req_addr  = $urandom();
            req_wdata = rand_data();
            req_bsel  = BWID'($urandom());
            ack_out   = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            rsp_ready = ($urandom_range(0, 3) != 0);
            rou_in_seen = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r < 4)      rou_in = '0;
            else if (r < 9) rou_in = mk(2'b11, TWID'($urandom_range(1, NOUT)), '0, '0, rand_data());
            else            rou_in = mk(2'($urandom_range(1, 3)), TWID'($urandom()), BWID'($urandom()), $urandom(), rand_data());

            lowest = 0;
            for (int t = NOUT; t >= 1; t--) if (!m_pend[t]) lowest = t;
            any_free = (lowest != 0);
            exp_busy = (m_out != '0);
            for (int t = 1; t <= NOUT; t++) if (m_pend[t]) exp_busy = 1;
            exp_rdy = ((m_out == '0) || (ack_out != 0)) && (req_write || any_free);
            ik = rou_in[1:0];
            itag = rou_in[2 +: TWID];
            known = 0;
            if (ik == 2'b11 && itag >= 1 && itag <= NOUT) begin
                if (m_pend[itag]) known = 1;
            end
            acc = known && (!m_rv || rsp_ready);
            exp_err = (ik != 2'b00) && !known;
            exp_ack = (acc || exp_err) ? 3'd1 : 3'd0;

            #2;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd%0d_req_ready: got %b expected %b", cyc, req_ready, exp_rdy); end
            checks++; if (ack_in !== exp_ack) begin errors++; $display("FAIL rnd%0d_ack_in: got %0d expected %0d", cyc, ack_in, exp_ack); end
            checks++; if (err_unexp !== exp_err) begin errors++; $display("FAIL rnd%0d_err: got %b expected %b", cyc, err_unexp, exp_err); end
            checks++; if (rou_out !== m_out) begin errors++; $display("FAIL rnd%0d_rou_out: got %0h expected %0h", cyc, rou_out, m_out); end
            checks++; if (rou_out_seen !== 1'b0) begin errors++; $display("FAIL rnd%0d_seen: got %b expected 0", cyc, rou_out_seen); end
            checks++; if (rsp_valid !== m_rv) begin errors++; $display("FAIL rnd%0d_rsp_valid: got %b expected %b", cyc, rsp_valid, m_rv); end
            checks++; if (rsp_tag !== m_rt || rsp_data !== m_rd) begin errors++; $display("FAIL rnd%0d_rsp: got tag=%0d data=%0h expected tag=%0d data=%0h", cyc, rsp_tag, rsp_data, m_rt, m_rd); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd%0d_busy: got %b expected %b", cyc, busy, exp_busy); end

            if (req_valid && exp_rdy) begin
                if (req_write) m_out = mk(2'b01, '0, req_bsel, req_addr, req_wdata);
                else begin
                    m_out = mk(2'b10, TWID'(lowest), req_bsel, req_addr, '0);
                    m_pend[lowest] = 1;
                end
            end else if (ack_out != 0) begin
                m_out = '0;
            end
            if (acc) begin
                m_pend[itag] = 0;
                m_rv = 1; m_rt = itag; m_rd = rou_in[WID-1 -: DWID];
            end else if (rsp_ready) begin
                m_rv = 0;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_hold();
        test_reads_full();
        test_response();
        test_backpressure();
        test_unexpected();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
